// File: rtl/adder_pkg.sv
// Shared definitions for the sequential chunked adder: FSM state encoding,
// operation mode constants and a counter sizing helper.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Ceiling log2, used to size the chunk counter.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder. Each bit is a full adder made of two
// half-adder cells and an OR. Also exposes the carry into the MSB so the
// caller can derive signed overflow on the most significant chunk.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cmsb
);
  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    logic s1;
    logic c1;
    logic c2;
    half_adder u_ha0 (.x(x[i]), .y(y[i]), .s(s1),   .c(c1));
    half_adder u_ha1 (.x(s1),   .y(c[i]), .s(s[i]), .c(c2));
    assign c[i+1] = c1 | c2;
  end

  assign co   = c[CHUNK];
  assign cmsb = c[CHUNK-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: adds WIDTH-bit operands CHUNK bits per clock,
// carrying between cycles through a registered carry flop, with valid/ready
// handshakes on input and output.
// Optional build macro: SEQ_CHUNK_ADDER_SAT_EN (saturate sum on signed overflow).
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;

  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK-1:0]   s_chunk;
  logic               co_chunk;
  logic               cmsb_chunk;
  logic               last;
  logic               ovf_c;
  logic [WIDTH-1:0]   sum_next;
  logic [WIDTH-1:0]   sum_final;

`ifdef SEQ_CHUNK_ADDER_SAT_EN
  // Clamp to the signed limit in the direction of operand A's sign.
  function automatic logic signed [WIDTH-1:0] sat_limit(input logic neg);
    logic signed [WIDTH-1:0] smin;
    smin = WIDTH'(1) << (WIDTH - 1);
    return neg ? smin : ~smin;
  endfunction
`endif

  assign a_chunk = CHUNK'(a_q >> (int'(cnt_q) * CHUNK));
  assign b_chunk = CHUNK'(b_q >> (int'(cnt_q) * CHUNK));
  assign last    = (cnt_q == CNT_W'(NCHUNK - 1));
  assign ovf_c   = cmsb_chunk ^ co_chunk;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .x    (a_chunk),
    .y    (b_chunk),
    .ci   (carry_q),
    .s    (s_chunk),
    .co   (co_chunk),
    .cmsb (cmsb_chunk)
  );

  // Merge the current chunk into the running sum and apply optional clamping.
  always_comb begin
    sum_next = sum_q;
    sum_next[int'(cnt_q)*CHUNK +: CHUNK] = s_chunk;
    sum_final = sum_next;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
    if (ovf_c) sum_final = sat_limit(a_q[WIDTH-1]);
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture; B is inverted up front for subtraction.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && in_valid) begin
      a_q <= a;
      b_q <= (sub == MODE_SUB) ? ~b : b;
    end
  end

  // Chunk counter, carry flop and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            carry_q <= (sub == MODE_SUB) ? 1'b1 : cin;
            cnt_q   <= '0;
          end
        end
        ST_BUSY: begin
          carry_q <= co_chunk;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last) begin
            sum_q  <= sum_final;
            cout_q <= co_chunk;
            ovf_q  <= ovf_c;
          end else begin
            sum_q  <= sum_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder: directed and random operations
// compared against an arithmetic reference model.
module tb_seq_chunk_adder;
  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, returns {ovf, cout, sum}.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic ci, input logic s);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] r;
    logic             v;
    if (s) full = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
    else   full = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
    r = full[WIDTH-1:0];
    if (s) v = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    else   v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
`ifdef SEQ_CHUNK_ADDER_SAT_EN
    if (v) r = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    return {v, full[WIDTH], r};
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                        input logic xc, input logic xs, input int hold);
    logic [WIDTH+1:0] exp;
    int lat;
    exp = model(xa, xb, xc, xs);
    check_val("in_ready_idle", in_ready, 1);
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check_val("latency", lat, NCHUNK);
    check_val("sum", sum, exp[WIDTH-1:0]);
    check_val("cout", cout, exp[WIDTH]);
    check_val("ovf", ovf, exp[WIDTH+1]);
    for (int h = 0; h < hold; h++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); in_valid = 1'($urandom);
      @(posedge clk); #1;
      check_val("hold_valid", out_valid, 1);
      check_val("hold_in_ready", in_ready, 0);
      check_val("hold_result", {ovf, cout, sum}, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("post_hs_valid", out_valid, 0);
    check_val("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check_val("rst_sum", sum, 0);
    check_val("rst_flags", {out_valid, busy, cout, ovf}, 0);
    check_val("rst_in_ready", in_ready, 1);

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
    run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 2);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 5);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0);

    // Reset two cycles into BUSY drops the operation.
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_val("busy_mid", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("midrst_valid", out_valid, 0);
    check_val("midrst_in_ready", in_ready, 1);
    check_val("midrst_sum", sum, 0);
    check_val("midrst_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_val("midrst_no_valid", seen, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
